// File: rtl/hazard_stall_unit.sv
// LC-3b pipeline hazard/stall control: load-use bubbles and data-memory wait stalls.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic             id_sr1_used,
    input  logic             id_sr2_used,
    input  logic [2:0]       id_ex_dest,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic             ex_mem_mem_access,
    input  logic             mem_resp,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             mem_timeout
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    logic       w_mem_hold;
    logic       w_load_use;
    logic [7:0] w_wait_next;

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("hazard_stall_unit: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
    end

    assign w_mem_hold  = ex_mem_mem_access && !mem_resp;
    assign w_load_use  = id_ex_mem_read && id_ex_reg_write &&
                         ((id_sr1_used && (id_sr1 == id_ex_dest)) ||
                          (id_sr2_used && (id_sr2 == id_ex_dest)));
    assign w_wait_next = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

    // Memory wait freezes the whole front end and masks any load-use bubble;
    // the bubble then fires in the first cycle the memory releases.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (w_mem_hold) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign mem_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_hold) r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (w_mem_hold) begin
                        r_wait_cnt <= w_wait_next;
                        if (w_wait_next == 8'(MEM_TIMEOUT)) r_timeout <= 1'b1;
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)     r_stall_cnt <= '0;
        else if (pc_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus random stimulus
// against a rule-level reference model; two instances cover MEM_TIMEOUT=255 and 3.
module tb_hazard_stall_unit;

    localparam int unsigned TO_A = 255;
    localparam int unsigned TO_B = 3;
    localparam int unsigned CW   = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] id_sr1, id_sr2, id_ex_dest;
    logic       id_sr1_used, id_sr2_used, id_ex_reg_write, id_ex_mem_read;
    logic       ex_mem_mem_access, mem_resp;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, mem_wb_bubble;
    logic mem_timeout_a;
    logic pc_stall_b, if_id_stall_b, id_ex_stall_b, ex_mem_stall_b, id_ex_bubble_b, mem_wb_bubble_b;
    logic mem_timeout_b;
`ifdef HAZARD_STALL_CNT_EN
    logic [CW-1:0] stall_count_a, stall_count_b;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: consecutive hold edges since last release/reset.
    int          m_hold_edges = 0;
    bit          m_to_a = 1'b0;
    bit          m_to_b = 1'b0;
    int unsigned m_stalls = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(TO_A), .CNT_W(CW)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .id_ex_dest(id_ex_dest), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_mem_access(ex_mem_mem_access), .mem_resp(mem_resp),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout(mem_timeout_a)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_count(stall_count_a)
`endif
    );

    hazard_stall_unit #(.MEM_TIMEOUT(TO_B), .CNT_W(CW)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .id_ex_dest(id_ex_dest), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_mem_access(ex_mem_mem_access), .mem_resp(mem_resp),
        .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b), .id_ex_stall(id_ex_stall_b),
        .ex_mem_stall(ex_mem_stall_b), .id_ex_bubble(id_ex_bubble_b), .mem_wb_bubble(mem_wb_bubble_b),
        .mem_timeout(mem_timeout_b)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_count(stall_count_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
        id_ex_dest = 3'd0; id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0;
        ex_mem_mem_access = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic set_load_use(input logic [2:0] r);
        id_ex_dest = r; id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1;
        id_sr1 = r; id_sr1_used = 1'b1;
    endtask

    // One clock: check outputs mid-cycle against the rules, then advance the model.
    task automatic cycle();
        bit hold, lu, e_pc, e_bub;
        @(negedge clk);
        hold  = ex_mem_mem_access && !mem_resp;
        lu    = id_ex_mem_read && id_ex_reg_write &&
                ((id_sr1_used && id_sr1 == id_ex_dest) || (id_sr2_used && id_sr2 == id_ex_dest));
        e_pc  = hold || lu;
        e_bub = lu && !hold;
        chk("pc_stall",      {31'd0, pc_stall},      {31'd0, e_pc});
        chk("if_id_stall",   {31'd0, if_id_stall},   {31'd0, e_pc});
        chk("id_ex_stall",   {31'd0, id_ex_stall},   {31'd0, hold});
        chk("ex_mem_stall",  {31'd0, ex_mem_stall},  {31'd0, hold});
        chk("mem_wb_bubble", {31'd0, mem_wb_bubble}, {31'd0, hold});
        chk("id_ex_bubble",  {31'd0, id_ex_bubble},  {31'd0, e_bub});
        chk("b_outputs", {26'd0, pc_stall_b, if_id_stall_b, id_ex_stall_b, ex_mem_stall_b,
                          id_ex_bubble_b, mem_wb_bubble_b},
                         {26'd0, e_pc, e_pc, hold, hold, e_bub, hold});
        chk("mem_timeout_255", {31'd0, mem_timeout_a}, {31'd0, m_to_a});
        chk("mem_timeout_3",   {31'd0, mem_timeout_b}, {31'd0, m_to_b});
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_count_a", {16'd0, stall_count_a}, m_stalls);
        chk("stall_count_b", {16'd0, stall_count_b}, m_stalls);
`endif
        @(posedge clk);
        if (!reset_n) begin
            m_hold_edges = 0; m_to_a = 1'b0; m_to_b = 1'b0; m_stalls = 0;
        end else begin
            if (hold) begin
                m_hold_edges++;
                // first hold edge only enters the wait; later ones count
                if (m_hold_edges > int'(TO_A)) m_to_a = 1'b1;
                if (m_hold_edges > int'(TO_B)) m_to_b = 1'b1;
            end else begin
                m_hold_edges = 0;
            end
            if (e_pc) m_stalls = (m_stalls + 1) % (1 << CW);
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        cycle();
        cycle();
        chk("reset_timeout", {30'd0, mem_timeout_a, mem_timeout_b}, 32'd0);
        reset_n = 1'b1;

        // Load-use on sr1: one bubble, then EX holds the bubble and all is quiet
        set_load_use(3'd3);
        cycle();
        set_idle();
        cycle();

        // sr2 matches but unused; then non-load producer
        id_ex_dest = 3'd3; id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1;
        id_sr2 = 3'd3; id_sr2_used = 1'b0; id_sr1 = 3'd5; id_sr1_used = 1'b1;
        cycle();
        id_ex_mem_read = 1'b0; id_sr1 = 3'd3;
        cycle();
        set_idle();

        // Same-cycle response: no stall
        ex_mem_mem_access = 1'b1; mem_resp = 1'b1;
        cycle();

        // Four-cycle memory wait
        mem_resp = 1'b0;
        repeat (4) cycle();
        mem_resp = 1'b1;
        cycle();
        set_idle();
        cycle();
        chk("wait4_timeout_255", {31'd0, mem_timeout_a}, 32'd0);
        chk("wait4_timeout_3",   {31'd0, mem_timeout_b}, 32'd1);

        // Ten-cycle wait: sticky timeout, cleared only by reset
        do_reset();
        ex_mem_mem_access = 1'b1; mem_resp = 1'b0;
        repeat (10) cycle();
        mem_resp = 1'b1;
        cycle();
        set_idle();
        repeat (2) cycle();
        chk("sticky_timeout_3", {31'd0, mem_timeout_b}, 32'd1);
        do_reset();
        chk("timeout_cleared", {31'd0, mem_timeout_b}, 32'd0);

        // Load-use masked during a 2-cycle wait, bubble once after response
        set_load_use(3'd6);
        ex_mem_mem_access = 1'b1; mem_resp = 1'b0;
        repeat (2) cycle();
        mem_resp = 1'b1;
        cycle();
        set_idle();
        cycle();

        // Two load-use stalls plus a 3-cycle wait, then reset mid-wait
        do_reset();
        set_load_use(3'd1); cycle(); set_idle(); cycle();
        set_load_use(3'd2); cycle(); set_idle(); cycle();
        ex_mem_mem_access = 1'b1; mem_resp = 1'b0;
        repeat (3) cycle();
        set_idle();
        cycle();
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_count_5", {16'd0, stall_count_a}, 32'd5);
`endif
        ex_mem_mem_access = 1'b1; mem_resp = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_count_reset", {16'd0, stall_count_a}, 32'd0);
`endif
        // After reset the wait restarts from RUN: 4 more holds reach the MEM_TIMEOUT=3 mark
        repeat (3) cycle();
        chk("restart_no_timeout", {31'd0, mem_timeout_b}, 32'd0);
        cycle();
        chk("restart_timeout", {31'd0, mem_timeout_b}, 32'd1);

        // Long wait: default timeout at the 255 boundary and counter saturation
        do_reset();
        ex_mem_mem_access = 1'b1; mem_resp = 1'b0;
        repeat (255) cycle();
        chk("wait255_before", {31'd0, mem_timeout_a}, 32'd0);
        cycle();
        chk("wait255_set", {31'd0, mem_timeout_a}, 32'd1);
        repeat (40) cycle();
        mem_resp = 1'b1;
        cycle();

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_sr1            = 3'($urandom_range(0, 3));
            id_sr2            = 3'($urandom_range(0, 3));
            id_ex_dest        = 3'($urandom_range(0, 3));
            id_sr1_used       = 1'($urandom_range(0, 1));
            id_sr2_used       = 1'($urandom_range(0, 1));
            id_ex_reg_write   = 1'($urandom_range(0, 3) != 0);
            id_ex_mem_read    = 1'($urandom_range(0, 1));
            ex_mem_mem_access = 1'($urandom_range(0, 1));
            mem_resp          = 1'($urandom_range(0, 4) == 0);
            reset_n           = 1'($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
